funct_sequencer: RTL and testbench
==================================

FUNCT_SEQUENCER -- requirements
Module: funct_sequencer

Interface
REQ-001 SHALL have parameter: MUL_CYCLES, default 32, number of multiplier step cycles for MULTU (legal 1..63).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: InValid  input  1  requester presents an operation.
REQ-005 SHALL have port: Funct  input  6  funct code of presented operation.
REQ-006 SHALL have port: InReady  output  1  sequencer can accept an operation.
REQ-007 SHALL have port: Signal  output  6  funct code driven to ALU, shifter, HiLo and result mux.
REQ-008 SHALL have port: MulEn  output  1  multiplier step enable.
REQ-009 SHALL have port: MulCnt  output  6  current multiplier step index.
REQ-010 SHALL have port: HiLoWe  output  1  HiLo register write strobe.
REQ-011 SHALL have port: OutValid  output  1  result/completion pulse.
REQ-012 SHALL have port: IllegalOp  output  1  completed operation had an undecoded funct.

Function
REQ-013 SHALL decode: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MFHI 010000, MFLO 010010 as single-cycle ops; MULTU 011001 as multi-cycle op; any other code as illegal.
REQ-014 SHALL implement states IDLE, EXEC, MUL, WB.
REQ-015 SHALL assert InReady only in IDLE; an operation is accepted on a rising edge where InValid=1 and InReady=1, and Funct is latched at that edge.
REQ-016 SHALL ignore Funct and InValid in all states other than IDLE (no queueing).
REQ-017 SHALL transition IDLE->EXEC on acceptance of a single-cycle or illegal op, and IDLE->MUL on acceptance of MULTU.
REQ-018 SHALL, in EXEC (exactly one cycle), drive Signal = latched funct, OutValid=1, IllegalOp=1 iff latched funct is illegal, then return to IDLE.
REQ-019 SHALL drive Signal=000000 for illegal ops in EXEC, so the result mux outputs zero.
REQ-020 SHALL, in MUL, drive Signal=011001, MulEn=1, MulCnt counting 0,1,...,MUL_CYCLES-1 (one increment per cycle, starting at 0 on the first MUL cycle).
REQ-021 SHALL transition MUL->WB on the cycle where MulCnt=MUL_CYCLES-1, and stay in MUL for exactly MUL_CYCLES cycles.
REQ-022 SHALL, in WB (exactly one cycle), drive Signal=011001, HiLoWe=1, OutValid=1, MulEn=0, then return to IDLE.
REQ-023 SHALL, in IDLE, drive Signal=000000, MulEn=0, MulCnt=0, HiLoWe=0, OutValid=0, IllegalOp=0.
REQ-024 SHALL give latency: single-cycle op OutValid 1 cycle after acceptance; MULTU OutValid/HiLoWe MUL_CYCLES+1 cycles after acceptance.
REQ-025 SHALL allow back-to-back operation: InReady=1 in the IDLE cycle right after EXEC or WB, so throughput for single-cycle ops is one op per 2 cycles.
REQ-026 SHALL guarantee MFHI/MFLO issued after MULTU observe the written HiLo (structurally ensured by REQ-015/REQ-022).
REQ-027 SHALL assert HiLoWe only in WB and never more than once per accepted MULTU.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, MulCnt=0 and all outputs to IDLE values (InReady=1 once reset is released, 0 while asserted), independent of clk.
REQ-029 SHALL, on reset mid-MUL or mid-EXEC, abandon the operation with no HiLoWe and no OutValid pulse.
REQ-030 SHALL resume normal acceptance on the first rising edge after reset returns to 1.

Verification
REQ-031 SHALL cover: reset release, InValid=1 Funct=100000 -> next cycle Signal=100000, OutValid=1, IllegalOp=0; following cycle InReady=1.
REQ-032 SHALL cover: Funct=011001 with MUL_CYCLES=32 -> MulEn=1 for 32 cycles, MulCnt 0..31, then one cycle HiLoWe=1 OutValid=1 at cycle 33 after acceptance.
REQ-033 SHALL cover: MULTU accepted, then InValid=1 Funct=010000 held -> MFHI ignored until IDLE, then accepted; Signal=010000 one cycle after WB+1.
REQ-034 SHALL cover: Funct=111111 -> EXEC cycle with Signal=000000, OutValid=1, IllegalOp=1.
REQ-035 SHALL cover: reset=0 asserted at MulCnt=10 -> immediately IDLE outputs, MulCnt=0, no HiLoWe ever pulsed for that op.
REQ-036 SHALL cover: Funct changed while InValid=0 and during EXEC -> no acceptance, Signal unaffected.

Source files
------------

// File: rtl/funct_sequencer_if.sv
// rtl/funct_sequencer_if.sv - requester/sequencer handshake and control outputs for funct_sequencer
interface funct_sequencer_if;
    logic       InValid;
    logic [5:0] Funct;
    logic       InReady;
    logic [5:0] Signal;
    logic       MulEn;
    logic [5:0] MulCnt;
    logic       HiLoWe;
    logic       OutValid;
    logic       IllegalOp;

    modport master (
        output InValid, Funct,
        input  InReady, Signal, MulEn, MulCnt, HiLoWe, OutValid, IllegalOp
    );

    modport slave (
        input  InValid, Funct,
        output InReady, Signal, MulEn, MulCnt, HiLoWe, OutValid, IllegalOp
    );
endinterface

// File: rtl/funct_sequencer.sv
// rtl/funct_sequencer.sv - funct-code sequencer: single-cycle ops, multi-cycle MULTU and HiLo writeback
module funct_sequencer #(
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    funct_sequencer_if.slave bus
);
    localparam logic [5:0] F_MULTU  = 6'b011001;
    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t     state;
    logic [5:0] signal_q;
    logic       mul_en_q;
    logic [5:0] mul_cnt_q;
    logic       hilo_we_q;
    logic       out_valid_q;
    logic       illegal_q;

    function automatic logic is_single(input logic [5:0] f);
        case (f)
            6'b100100, 6'b100101, 6'b100000, 6'b100010,
            6'b101010, 6'b000010, 6'b010000, 6'b010010: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // Outputs are registered from the next state, so each state's values
    // appear during the cycle the FSM occupies that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            signal_q    <= 6'b0;
            mul_en_q    <= 1'b0;
            mul_cnt_q   <= 6'b0;
            hilo_we_q   <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            signal_q    <= 6'b0;
            mul_en_q    <= 1'b0;
            mul_cnt_q   <= 6'b0;
            hilo_we_q   <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.InValid) begin
                        if (bus.Funct == F_MULTU) begin
                            state    <= MUL;
                            signal_q <= F_MULTU;
                            mul_en_q <= 1'b1;
                        end else begin
                            state       <= EXEC;
                            out_valid_q <= 1'b1;
                            // Undecoded codes drive zero so the result mux yields zero.
                            if (is_single(bus.Funct)) signal_q  <= bus.Funct;
                            else                      illegal_q <= 1'b1;
                        end
                    end
                end
                EXEC: state <= IDLE;
                MUL: begin
                    signal_q <= F_MULTU;
                    if (mul_cnt_q == MUL_LAST) begin
                        state       <= WB;
                        hilo_we_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        mul_en_q  <= 1'b1;
                        mul_cnt_q <= mul_cnt_q + 6'd1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by reset so the requester sees not-ready while reset is held.
    assign bus.InReady   = (state == IDLE) && reset;
    assign bus.Signal    = signal_q;
    assign bus.MulEn     = mul_en_q;
    assign bus.MulCnt    = mul_cnt_q;
    assign bus.HiLoWe    = hilo_we_q;
    assign bus.OutValid  = out_valid_q;
    assign bus.IllegalOp = illegal_q;
endmodule

// File: tb/tb_funct_sequencer.sv
// tb/tb_funct_sequencer.sv - scoreboard bench for funct_sequencer
module tb_funct_sequencer;
    localparam int MUL_CYCLES = 32;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_MFHI  = 6'b010000;

    typedef struct {
        logic [5:0] sig;
        logic       ill;
        logic       we;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   mul_idx = 0;
    exp_t sb[$];

    funct_sequencer_if bus();

    funct_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input int c);
        exp_t e;
        e.ill = 1'b0;
        e.we  = 1'b0;
        e.sig = f;
        e.due = c + 1;
        case (f)
            6'b100100, 6'b100101, 6'b100000, 6'b100010,
            6'b101010, 6'b000010, 6'b010000, 6'b010010: ;
            6'b011001: begin e.we = 1'b1; e.due = c + 1 + MUL_CYCLES; end
            default:   begin e.ill = 1'b1; e.sig = 6'b0; end
        endcase
        return e;
    endfunction

    // Monitor: pushes on acceptance, pops and compares on every OutValid.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            mul_idx = 0;
        end else begin
            if (bus.MulEn) begin
                check("mul_cnt", int'(bus.MulCnt), mul_idx);
                check("mul_signal", int'(bus.Signal), int'(F_MULTU));
                mul_idx++;
            end
            if (bus.HiLoWe) check("hilowe_with_outvalid", int'(bus.OutValid), 1);
            if (bus.OutValid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_outvalid: got OutValid=1 with Signal=%b, expected none at cycle %0d",
                             bus.Signal, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_signal", int'(bus.Signal), int'(e.sig));
                    check("out_illegal", int'(bus.IllegalOp), int'(e.ill));
                    check("out_hilowe", int'(bus.HiLoWe), int'(e.we));
                    check("out_latency", cyc, e.due);
                    if (e.we) check("mul_steps", mul_idx, MUL_CYCLES);
                    mul_idx = 0;
                end
            end
            if (bus.InValid && bus.InReady) sb.push_back(model(bus.Funct, cyc));
        end
    end

    task automatic issue(input logic [5:0] f, output int acc);
        bus.Funct   = f;
        bus.InValid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.InReady) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        if (acc < 0) check("accept_timeout", acc, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_signal"}, int'(bus.Signal), 0);
        check({tag, "_mulen"}, int'(bus.MulEn), 0);
        check({tag, "_mulcnt"}, int'(bus.MulCnt), 0);
        check({tag, "_hilowe"}, int'(bus.HiLoWe), 0);
        check({tag, "_outvalid"}, int'(bus.OutValid), 0);
        check({tag, "_illegal"}, int'(bus.IllegalOp), 0);
    endtask

    initial begin
        logic [5:0] ops [11];
        int a0, a1, rc;
        bit hit;
        ops = '{6'b100000, 6'b100100, 6'b100101, 6'b100010, 6'b101010, 6'b000010,
                6'b010000, 6'b010010, 6'b111111, 6'b000000, 6'b011001};
        reset       = 1'b0;
        bus.InValid = 1'b0;
        bus.Funct   = 6'b0;
        #3;
        check_idle_outputs("reset");
        check("reset_inready", int'(bus.InReady), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("release_inready", int'(bus.InReady), 1);
        check_idle_outputs("idle");

        foreach (ops[i]) issue(ops[i], a0);

        // Back-to-back single-cycle ops: one accept every two cycles.
        issue(F_ADD, a0);
        issue(F_SUB, a1);
        check("back_to_back_gap", a1 - a0, 2);

        // MFHI held during MULTU is accepted in the IDLE cycle after WB.
        issue(F_MULTU, a0);
        issue(F_MFHI, a1);
        check("mfhi_after_wb", a1 - a0, MUL_CYCLES + 2);

        // Funct changes during EXEC and while InValid=0 are ignored.
        issue(F_ADD, a0);
        bus.Funct = F_AND;
        @(negedge clk);
        check("exec_signal_held", int'(bus.Signal), int'(F_ADD));
        for (int i = 0; i < 3; i++) begin
            bus.Funct = 6'(i * 21 + 5);
            @(negedge clk);
            check("novalid_signal", int'(bus.Signal), 0);
            check("novalid_outvalid", int'(bus.OutValid), 0);
        end

        // Reset asserted mid-MUL abandons the op with no writeback.
        issue(F_MULTU, a0);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.MulCnt == 6'd10) begin
                hit = 1;
                break;
            end
        end
        check("reached_mulcnt_10", int'(hit), 1);
        #1 reset = 1'b0;
        #1;
        check_idle_outputs("midmul_reset");
        check("midmul_inready", int'(bus.InReady), 0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold_mulcnt", int'(bus.MulCnt), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        rc = cyc;
        issue(F_ADD, a0);
        check("resume_first_edge", a0, rc);
        repeat (MUL_CYCLES + 4) @(negedge clk);
        check("no_hilowe_after_abort", int'(bus.HiLoWe), 0);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
